// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one 128-bit round-key register advanced once per clock.
// Optional AES_KEY_STORE_EN adds an 11-entry round-key store with a combinational read port.
module aes_key_expand #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [127:0]  key,
    output logic          busy,
    output logic          rk_valid,
    output logic [RW-1:0] rk_round,
    output logic [127:0]  rk,
    output logic          done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [RW-1:0] rd_idx,
    output logic [127:0]  rd_key
`endif
);

    // state  | meaning
    // IDLE   | waiting for start; rk/rk_round hold the last presented key
    // EXPAND | presenting round keys 0..NR, one per cycle
    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [RW-1:0] LAST = RW'(NR);

    state_t        state, state_next;
    logic [127:0]  rk_reg;
    logic [RW-1:0] round_q;
    logic [7:0]    rcon_q;
    logic          load, advance;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = 8'h00;
        case (x)
            8'h00: sbox = 8'h63; 8'h01: sbox = 8'h7c; 8'h02: sbox = 8'h77; 8'h03: sbox = 8'h7b; 8'h04: sbox = 8'hf2; 8'h05: sbox = 8'h6b; 8'h06: sbox = 8'h6f; 8'h07: sbox = 8'hc5;
            8'h08: sbox = 8'h30; 8'h09: sbox = 8'h01; 8'h0a: sbox = 8'h67; 8'h0b: sbox = 8'h2b; 8'h0c: sbox = 8'hfe; 8'h0d: sbox = 8'hd7; 8'h0e: sbox = 8'hab; 8'h0f: sbox = 8'h76;
            8'h10: sbox = 8'hca; 8'h11: sbox = 8'h82; 8'h12: sbox = 8'hc9; 8'h13: sbox = 8'h7d; 8'h14: sbox = 8'hfa; 8'h15: sbox = 8'h59; 8'h16: sbox = 8'h47; 8'h17: sbox = 8'hf0;
            8'h18: sbox = 8'had; 8'h19: sbox = 8'hd4; 8'h1a: sbox = 8'ha2; 8'h1b: sbox = 8'haf; 8'h1c: sbox = 8'h9c; 8'h1d: sbox = 8'ha4; 8'h1e: sbox = 8'h72; 8'h1f: sbox = 8'hc0;
            8'h20: sbox = 8'hb7; 8'h21: sbox = 8'hfd; 8'h22: sbox = 8'h93; 8'h23: sbox = 8'h26; 8'h24: sbox = 8'h36; 8'h25: sbox = 8'h3f; 8'h26: sbox = 8'hf7; 8'h27: sbox = 8'hcc;
            8'h28: sbox = 8'h34; 8'h29: sbox = 8'ha5; 8'h2a: sbox = 8'he5; 8'h2b: sbox = 8'hf1; 8'h2c: sbox = 8'h71; 8'h2d: sbox = 8'hd8; 8'h2e: sbox = 8'h31; 8'h2f: sbox = 8'h15;
            8'h30: sbox = 8'h04; 8'h31: sbox = 8'hc7; 8'h32: sbox = 8'h23; 8'h33: sbox = 8'hc3; 8'h34: sbox = 8'h18; 8'h35: sbox = 8'h96; 8'h36: sbox = 8'h05; 8'h37: sbox = 8'h9a;
            8'h38: sbox = 8'h07; 8'h39: sbox = 8'h12; 8'h3a: sbox = 8'h80; 8'h3b: sbox = 8'he2; 8'h3c: sbox = 8'heb; 8'h3d: sbox = 8'h27; 8'h3e: sbox = 8'hb2; 8'h3f: sbox = 8'h75;
            8'h40: sbox = 8'h09; 8'h41: sbox = 8'h83; 8'h42: sbox = 8'h2c; 8'h43: sbox = 8'h1a; 8'h44: sbox = 8'h1b; 8'h45: sbox = 8'h6e; 8'h46: sbox = 8'h5a; 8'h47: sbox = 8'ha0;
            8'h48: sbox = 8'h52; 8'h49: sbox = 8'h3b; 8'h4a: sbox = 8'hd6; 8'h4b: sbox = 8'hb3; 8'h4c: sbox = 8'h29; 8'h4d: sbox = 8'he3; 8'h4e: sbox = 8'h2f; 8'h4f: sbox = 8'h84;
            8'h50: sbox = 8'h53; 8'h51: sbox = 8'hd1; 8'h52: sbox = 8'h00; 8'h53: sbox = 8'hed; 8'h54: sbox = 8'h20; 8'h55: sbox = 8'hfc; 8'h56: sbox = 8'hb1; 8'h57: sbox = 8'h5b;
            8'h58: sbox = 8'h6a; 8'h59: sbox = 8'hcb; 8'h5a: sbox = 8'hbe; 8'h5b: sbox = 8'h39; 8'h5c: sbox = 8'h4a; 8'h5d: sbox = 8'h4c; 8'h5e: sbox = 8'h58; 8'h5f: sbox = 8'hcf;
            8'h60: sbox = 8'hd0; 8'h61: sbox = 8'hef; 8'h62: sbox = 8'haa; 8'h63: sbox = 8'hfb; 8'h64: sbox = 8'h43; 8'h65: sbox = 8'h4d; 8'h66: sbox = 8'h33; 8'h67: sbox = 8'h85;
            8'h68: sbox = 8'h45; 8'h69: sbox = 8'hf9; 8'h6a: sbox = 8'h02; 8'h6b: sbox = 8'h7f; 8'h6c: sbox = 8'h50; 8'h6d: sbox = 8'h3c; 8'h6e: sbox = 8'h9f; 8'h6f: sbox = 8'ha8;
            8'h70: sbox = 8'h51; 8'h71: sbox = 8'ha3; 8'h72: sbox = 8'h40; 8'h73: sbox = 8'h8f; 8'h74: sbox = 8'h92; 8'h75: sbox = 8'h9d; 8'h76: sbox = 8'h38; 8'h77: sbox = 8'hf5;
            8'h78: sbox = 8'hbc; 8'h79: sbox = 8'hb6; 8'h7a: sbox = 8'hda; 8'h7b: sbox = 8'h21; 8'h7c: sbox = 8'h10; 8'h7d: sbox = 8'hff; 8'h7e: sbox = 8'hf3; 8'h7f: sbox = 8'hd2;
            8'h80: sbox = 8'hcd; 8'h81: sbox = 8'h0c; 8'h82: sbox = 8'h13; 8'h83: sbox = 8'hec; 8'h84: sbox = 8'h5f; 8'h85: sbox = 8'h97; 8'h86: sbox = 8'h44; 8'h87: sbox = 8'h17;
            8'h88: sbox = 8'hc4; 8'h89: sbox = 8'ha7; 8'h8a: sbox = 8'h7e; 8'h8b: sbox = 8'h3d; 8'h8c: sbox = 8'h64; 8'h8d: sbox = 8'h5d; 8'h8e: sbox = 8'h19; 8'h8f: sbox = 8'h73;
            8'h90: sbox = 8'h60; 8'h91: sbox = 8'h81; 8'h92: sbox = 8'h4f; 8'h93: sbox = 8'hdc; 8'h94: sbox = 8'h22; 8'h95: sbox = 8'h2a; 8'h96: sbox = 8'h90; 8'h97: sbox = 8'h88;
            8'h98: sbox = 8'h46; 8'h99: sbox = 8'hee; 8'h9a: sbox = 8'hb8; 8'h9b: sbox = 8'h14; 8'h9c: sbox = 8'hde; 8'h9d: sbox = 8'h5e; 8'h9e: sbox = 8'h0b; 8'h9f: sbox = 8'hdb;
            8'ha0: sbox = 8'he0; 8'ha1: sbox = 8'h32; 8'ha2: sbox = 8'h3a; 8'ha3: sbox = 8'h0a; 8'ha4: sbox = 8'h49; 8'ha5: sbox = 8'h06; 8'ha6: sbox = 8'h24; 8'ha7: sbox = 8'h5c;
            8'ha8: sbox = 8'hc2; 8'ha9: sbox = 8'hd3; 8'haa: sbox = 8'hac; 8'hab: sbox = 8'h62; 8'hac: sbox = 8'h91; 8'had: sbox = 8'h95; 8'hae: sbox = 8'he4; 8'haf: sbox = 8'h79;
            8'hb0: sbox = 8'he7; 8'hb1: sbox = 8'hc8; 8'hb2: sbox = 8'h37; 8'hb3: sbox = 8'h6d; 8'hb4: sbox = 8'h8d; 8'hb5: sbox = 8'hd5; 8'hb6: sbox = 8'h4e; 8'hb7: sbox = 8'ha9;
            8'hb8: sbox = 8'h6c; 8'hb9: sbox = 8'h56; 8'hba: sbox = 8'hf4; 8'hbb: sbox = 8'hea; 8'hbc: sbox = 8'h65; 8'hbd: sbox = 8'h7a; 8'hbe: sbox = 8'hae; 8'hbf: sbox = 8'h08;
            8'hc0: sbox = 8'hba; 8'hc1: sbox = 8'h78; 8'hc2: sbox = 8'h25; 8'hc3: sbox = 8'h2e; 8'hc4: sbox = 8'h1c; 8'hc5: sbox = 8'ha6; 8'hc6: sbox = 8'hb4; 8'hc7: sbox = 8'hc6;
            8'hc8: sbox = 8'he8; 8'hc9: sbox = 8'hdd; 8'hca: sbox = 8'h74; 8'hcb: sbox = 8'h1f; 8'hcc: sbox = 8'h4b; 8'hcd: sbox = 8'hbd; 8'hce: sbox = 8'h8b; 8'hcf: sbox = 8'h8a;
            8'hd0: sbox = 8'h70; 8'hd1: sbox = 8'h3e; 8'hd2: sbox = 8'hb5; 8'hd3: sbox = 8'h66; 8'hd4: sbox = 8'h48; 8'hd5: sbox = 8'h03; 8'hd6: sbox = 8'hf6; 8'hd7: sbox = 8'h0e;
            8'hd8: sbox = 8'h61; 8'hd9: sbox = 8'h35; 8'hda: sbox = 8'h57; 8'hdb: sbox = 8'hb9; 8'hdc: sbox = 8'h86; 8'hdd: sbox = 8'hc1; 8'hde: sbox = 8'h1d; 8'hdf: sbox = 8'h9e;
            8'he0: sbox = 8'he1; 8'he1: sbox = 8'hf8; 8'he2: sbox = 8'h98; 8'he3: sbox = 8'h11; 8'he4: sbox = 8'h69; 8'he5: sbox = 8'hd9; 8'he6: sbox = 8'h8e; 8'he7: sbox = 8'h94;
            8'he8: sbox = 8'h9b; 8'he9: sbox = 8'h1e; 8'hea: sbox = 8'h87; 8'heb: sbox = 8'he9; 8'hec: sbox = 8'hce; 8'hed: sbox = 8'h55; 8'hee: sbox = 8'h28; 8'hef: sbox = 8'hdf;
            8'hf0: sbox = 8'h8c; 8'hf1: sbox = 8'ha1; 8'hf2: sbox = 8'h89; 8'hf3: sbox = 8'h0d; 8'hf4: sbox = 8'hbf; 8'hf5: sbox = 8'he6; 8'hf6: sbox = 8'h42; 8'hf7: sbox = 8'h68;
            8'hf8: sbox = 8'h41; 8'hf9: sbox = 8'h99; 8'hfa: sbox = 8'h2d; 8'hfb: sbox = 8'h0f; 8'hfc: sbox = 8'hb0; 8'hfd: sbox = 8'h54; 8'hfe: sbox = 8'hbb; 8'hff: sbox = 8'h16;
            default: sbox = 8'h00;
        endcase
    endfunction

    logic [31:0]  w3_rot, t_word;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [127:0] rk_next;

    // RotWord on w3, SubWord through the four shared S-boxes, then the word-chained XORs
    always_comb begin
        w3_rot  = {rk_reg[23:0], rk_reg[31:24]};
        t_word  = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
                   sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])} ^ {rcon_q, 24'h0};
        w0_n    = rk_reg[127:96] ^ t_word;
        w1_n    = rk_reg[95:64]  ^ w0_n;
        w2_n    = rk_reg[63:32]  ^ w1_n;
        w3_n    = rk_reg[31:0]   ^ w2_n;
        rk_next = {w0_n, w1_n, w2_n, w3_n};
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = EXPAND;
                    load       = 1'b1;
                end
            end
            EXPAND: begin
                if (round_q == LAST) state_next = IDLE;
                else                 advance    = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_reg  <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else if (load) begin
            rk_reg  <= key;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else if (advance) begin
            rk_reg  <= rk_next;
            round_q <= round_q + RW'(1);
            rcon_q  <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
    end

    assign busy     = (state == EXPAND);
    assign rk_valid = (state == EXPAND);
    assign done     = (state == EXPAND) && (round_q == LAST);
    assign rk       = rk_reg;
    assign rk_round = round_q;

`ifdef AES_KEY_STORE_EN
    logic [127:0] store [0:NR];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) store[i] <= '0;
        end else if (rk_valid) begin
            store[rk_round] <= rk_reg;
        end
    end

    assign rd_key = (rd_idx <= LAST) ? store[rd_idx] : 128'h0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized bench for aes_key_expand against a FIPS-197 word-array key expansion model.
// The S-box reference is derived from GF(2^8) inversion plus the affine map, not a table.
module tb_aes_key_expand;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [127:0]  key;
    logic          busy, rk_valid, done;
    logic [3:0]    rk_round;
    logic [127:0]  rk;
`ifdef AES_KEY_STORE_EN
    logic [3:0]    rd_idx;
    logic [127:0]  rd_key;
`endif

    aes_key_expand #(.NR(10), .RW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .rk       (rk),
        .done     (done)
`ifdef AES_KEY_STORE_EN
        ,
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sb_ref [256];
    logic [127:0] exp_rk [11];
    bit           kat1_en, kat10_en;
    logic [127:0] kat1, kat10;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts a run from the cycle just after an edge; returns one cycle after the done cycle.
    task automatic check_run(input logic [127:0] k, input bit disturb, input bit hold, input int abort_at);
        expand_model(k);
        key = k;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            check($sformatf("rk_valid r%0d", r), 128'(rk_valid), 128'(1));
            check($sformatf("busy r%0d", r), 128'(busy), 128'(1));
            check($sformatf("rk_round r%0d", r), 128'(rk_round), 128'(r));
            check($sformatf("rk r%0d", r), rk, exp_rk[r]);
            check($sformatf("done r%0d", r), 128'(done), 128'(r == 10));
            if (kat1_en && r == 1) check("kat round1", rk, kat1);
            if (kat10_en && r == 10) check("kat round10", rk, kat10);
            if (r == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort busy", 128'(busy), 128'(0));
                check("abort rk_valid", 128'(rk_valid), 128'(0));
                check("abort done", 128'(done), 128'(0));
                check("abort rk_round", 128'(rk_round), 128'(0));
                check("abort rk", rk, 128'h0);
                @(posedge clk); #1;
                rst = 1'b0;
                start = 1'b0;
                check("post-abort done", 128'(done), 128'(0));
                return;
            end
            if (disturb && (r == 4 || r == 10)) begin
                start = 1'b1;
                key = ~k;
            end else if (!hold) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = hold;
        check("idle busy", 128'(busy), 128'(0));
        check("idle rk_valid", 128'(rk_valid), 128'(0));
        check("idle done", 128'(done), 128'(0));
        check("idle rk hold", rk, exp_rk[10]);
        check("idle rk_round hold", 128'(rk_round), 128'(10));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sb_ref[i] = sbox_model(8'(i));
        kat1_en = 1'b0;
        kat10_en = 1'b0;
        kat1 = '0;
        kat10 = '0;
        rst = 1'b1;
        start = 1'b0;
        key = '0;
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 128'(busy), 128'(0));
        check("reset rk_valid", 128'(rk_valid), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset rk_round", 128'(rk_round), 128'(0));
        check("reset rk", rk, 128'h0);
`ifdef AES_KEY_STORE_EN
        check("reset rd_key", rd_key, 128'h0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle no start", 128'(busy), 128'(0));

        // FIPS-197 A.1 known answer
        kat1_en = 1'b1; kat10_en = 1'b1;
        kat1  = 128'ha0fafe1788542cb123a339392a6c7605;
        kat10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        check_run(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, -1);
        kat1_en = 1'b0; kat10_en = 1'b0;
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd1;  #1; check("store idx1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10; #1; check("store idx10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx = 4'd0;  #1; check("store idx0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_idx = 4'd11; #1; check("store idx11", rd_key, 128'h0);
        rd_idx = 4'd15; #1; check("store idx15", rd_key, 128'h0);
`endif

        // start pulses mid-run and on the done cycle are ignored; next-cycle start is taken
        check_run(rand_key(), 1'b1, 1'b0, -1);
        check_run(rand_key(), 1'b0, 1'b0, -1);

        // all-zero key, aborted by reset at round 4, then a clean restart
        kat1_en = 1'b1;
        kat1 = 128'h62636363626363636263636362636363;
        check_run(128'h0, 1'b0, 1'b0, 4);
        kat1_en = 1'b0;
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd1; #1; check("store cleared by reset", rd_key, 128'h0);
`endif
        check_run(rand_key(), 1'b0, 1'b0, -1);

        // back-to-back runs with start held high
        check_run(rand_key(), 1'b0, 1'b1, -1);
        check_run(rand_key(), 1'b0, 1'b1, -1);
        start = 1'b0;

        for (int n = 0; n < 4; n++) check_run(rand_key(), 1'b0, 1'b0, -1);
`ifdef AES_KEY_STORE_EN
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("store final idx%0d", i), rd_key, exp_rk[i]);
        end
`endif
        @(posedge clk); #1;
        check("final idle", 128'(busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
